// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, lane types and lane helper functions for the input stage
package game_pkg;

  // Lane count is fixed by the game board: four lane buttons.
  localparam int NUM_LANES = 4;

  // 10 ms of stable input at the 25 MHz game clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int CNT_W_DEFAULT = 18;

  // Bit positions of each lane inside a lane vector (bit0 = button_1).
  localparam int LANE_1 = 0;
  localparam int LANE_2 = 1;
  localparam int LANE_3 = 2;
  localparam int LANE_4 = 3;

  typedef logic [NUM_LANES-1:0] lane_vec_t;

  // One-hot of the lowest-index set bit; zero when nothing is set.
  function automatic lane_vec_t lowest_lane(input lane_vec_t v);
    lane_vec_t r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // True when more than one bit of the vector is set.
  function automatic logic multi_lane(input lane_vec_t v);
    return (v & (v - lane_vec_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - 2-flop synchroniser, counter debounce and rising-edge detect for one button
module debounce_cell
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  // Last count value before a pending level change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: synchronise, count consecutive disagreeing cycles, accept after a full window.
  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    if (sync2_q == stable_q) begin
      // Any agreement, even one cycle, restarts the window so glitches never land.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register; every flop clears as soon as reset asserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - lane/start button conditioning with a one-entry pending press for pix_gen
module button_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] btn_lane,
  input  logic                 btn_start,
  input  logic                 consume,
  output logic                 press_valid,
  output logic [NUM_LANES-1:0] press_lane,
  output logic                 start_pulse,
  output logic [NUM_LANES-1:0] lane_level,
  output logic                 multi_press,
  output logic                 overrun
);

  // Lanes occupy the low bits; the start button rides on the top bit.
  logic [NUM_LANES:0] raw_all;
  logic [NUM_LANES:0] level_all;
  logic [NUM_LANES:0] rise_all;

  assign raw_all = {btn_start, btn_lane};

  for (genvar gi = 0; gi <= NUM_LANES; gi++) begin : g_db
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_all[gi]),
      .level(level_all[gi]),
      .rise (rise_all[gi])
    );
  end

  lane_vec_t lane_rise;
  lane_vec_t first_rise;
  logic      any_rise;
  logic      start_rise;

  assign lane_rise  = rise_all[NUM_LANES-1:0];
  assign start_rise = rise_all[NUM_LANES];
  assign any_rise   = |lane_rise;
  assign first_rise = lowest_lane(lane_rise);

  logic      press_valid_q, press_valid_d;
  lane_vec_t press_lane_q, press_lane_d;
  logic      start_pulse_q, start_pulse_d;
  lane_vec_t lane_level_q, lane_level_d;
  logic      multi_press_q, multi_press_d;
  logic      overrun_q, overrun_d;

  // Pending-press priority: consume first (with same-cycle refill), then capture, else drop.
  always_comb begin
    press_valid_d = press_valid_q;
    press_lane_d  = press_lane_q;
    if (press_valid_q && consume) begin
      press_valid_d = any_rise;
      press_lane_d  = first_rise;
    end else if (!press_valid_q && any_rise) begin
      press_valid_d = 1'b1;
      press_lane_d  = first_rise;
    end
    overrun_d     = press_valid_q & ~consume & any_rise;
    multi_press_d = multi_lane(lane_rise);
    start_pulse_d = start_rise;
    lane_level_d  = level_all[NUM_LANES-1:0];
  end

  // Output register; a reset drops any press still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_valid_q <= 1'b0;
      press_lane_q  <= '0;
      start_pulse_q <= 1'b0;
      lane_level_q  <= '0;
      multi_press_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      press_valid_q <= press_valid_d;
      press_lane_q  <= press_lane_d;
      start_pulse_q <= start_pulse_d;
      lane_level_q  <= lane_level_d;
      multi_press_q <= multi_press_d;
      overrun_q     <= overrun_d;
    end
  end

  assign press_valid = press_valid_q;
  assign press_lane  = press_lane_q;
  assign start_pulse = start_pulse_q;
  assign lane_level  = lane_level_q;
  assign multi_press = multi_press_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench with a window-rule reference model for button_conditioner
module tb_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_lane = 4'b0000;
  logic       btn_start = 1'b0;
  logic       consume = 1'b0;
  logic       press_valid;
  logic [3:0] press_lane;
  logic       start_pulse;
  logic [3:0] lane_level;
  logic       multi_press;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_lane   (btn_lane),
    .btn_start  (btn_start),
    .consume    (consume),
    .press_valid(press_valid),
    .press_lane (press_lane),
    .start_pulse(start_pulse),
    .lane_level (lane_level),
    .multi_press(multi_press),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D synchronised samples all
  // agree on a value different from the current level.
  logic [4:0] m_dl1, m_dl2, m_st, m_st_prev;
  logic [4:0] m_win [D-1];
  logic       m_pv, m_start, m_multi, m_over;
  logic [3:0] m_pl, m_level;

  always @(posedge clk or posedge rst) begin : model
    logic [4:0] rise, sync_now, nst;
    logic [3:0] first;
    logic       agree;
    if (rst) begin
      m_dl1 <= '0; m_dl2 <= '0; m_st <= '0; m_st_prev <= '0;
      for (int i = 0; i < D - 1; i++) m_win[i] <= '0;
      m_pv <= 1'b0; m_pl <= '0; m_start <= 1'b0; m_level <= '0;
      m_multi <= 1'b0; m_over <= 1'b0;
    end else begin
      rise = m_st & ~m_st_prev;
      sync_now = m_dl2;
      nst = m_st;
      for (int b = 0; b < 5; b++) begin
        agree = (sync_now[b] != m_st[b]);
        for (int i = 0; i < D - 1; i++) if (m_win[i][b] != sync_now[b]) agree = 1'b0;
        if (agree) nst[b] = sync_now[b];
      end
      m_win[0] <= sync_now;
      for (int i = 1; i < D - 1; i++) m_win[i] <= m_win[i-1];
      m_dl1 <= {btn_start, btn_lane};
      m_dl2 <= m_dl1;
      m_st_prev <= m_st;
      m_st <= nst;
      first = 4'b0000;
      for (int k = 3; k >= 0; k--) if (rise[k]) first = 4'b0001 << k;
      m_level <= m_st[3:0];
      m_start <= rise[4];
      m_multi <= ($countones(rise[3:0]) > 1);
      m_over <= m_pv && !consume && (rise[3:0] != 4'b0000);
      if (m_pv && consume) begin
        m_pv <= (rise[3:0] != 4'b0000);
        m_pl <= first;
      end else if (!m_pv && rise[3:0] != 4'b0000) begin
        m_pv <= 1'b1;
        m_pl <= first;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      n_vec++;
      if ({press_valid, press_lane, start_pulse, lane_level, multi_press, overrun} !==
          {m_pv, m_pl, m_start, m_level, m_multi, m_over}) begin
        n_err++;
        $display("FAIL model_cmp t=%0t: got pv=%b pl=%b sp=%b lvl=%b mp=%b ov=%b, required pv=%b pl=%b sp=%b lvl=%b mp=%b ov=%b",
                 $time, press_valid, press_lane, start_pulse, lane_level, multi_press, overrun,
                 m_pv, m_pl, m_start, m_level, m_multi, m_over);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt;

  initial begin
    tick(2);
    chk("reset_pv", 32'(press_valid), 32'd0);
    chk("reset_pl", 32'(press_lane), 32'd0);
    chk("reset_sp", 32'(start_pulse), 32'd0);
    chk("reset_lvl", 32'(lane_level), 32'd0);
    chk("reset_mp_ov", 32'({multi_press, overrun}), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick(2);

    // 1: single press appears on the 7th edge after the input changes and holds.
    btn_lane = 4'b0001;
    tick(6);
    chk("t1_pv_early", 32'(press_valid), 32'd0);
    tick(1);
    chk("t1_pv", 32'(press_valid), 32'd1);
    chk("t1_pl", 32'(press_lane), 32'b0001);
    tick(4);
    chk("t1_pv_hold", 32'(press_valid), 32'd1);
    chk("t1_pl_hold", 32'(press_lane), 32'b0001);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    chk("t1_pv_consumed", 32'(press_valid), 32'd0);
    chk("t1_pl_consumed", 32'(press_lane), 32'd0);
    btn_lane = 4'b0000;
    tick(10);

    // 2: three-cycle glitch never gets through.
    btn_lane = 4'b0100;
    tick(3);
    btn_lane = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (press_valid || lane_level[2]) cnt++;
    end
    chk("t2_glitch", 32'(cnt), 32'd0);

    // 3: two lanes together -> lowest wins, one multi_press pulse.
    btn_lane = 4'b1010;
    tick(7);
    chk("t3_pl", 32'(press_lane), 32'b0010);
    chk("t3_mp", 32'(multi_press), 32'd1);
    tick(1);
    chk("t3_mp_end", 32'(multi_press), 32'd0);
    chk("t3_lvl", 32'(lane_level), 32'b1010);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    btn_lane = 4'b0000;
    tick(10);

    // 4: second press while one is pending is dropped with a single overrun.
    btn_lane = 4'b0001;
    tick(7);
    btn_lane = 4'b1001;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (overrun) cnt++;
    end
    chk("t4_overrun_count", 32'(cnt), 32'd1);
    chk("t4_pl", 32'(press_lane), 32'b0001);

    // 5: consume coinciding with a new rise refills without a bubble.
    btn_lane = 4'b0101;
    tick(6);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    chk("t5_pv", 32'(press_valid), 32'd1);
    chk("t5_pl", 32'(press_lane), 32'b0100);
    chk("t5_ov", 32'(overrun), 32'd0);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    btn_lane = 4'b0000;
    tick(10);

    // 6: held start gives exactly one pulse; reset mid-press clears everything.
    btn_start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (start_pulse) cnt++;
    end
    chk("t6_start_count", 32'(cnt), 32'd1);
    btn_start = 1'b0;
    tick(10);
    btn_lane = 4'b0010;
    tick(7);
    chk("t6_pv_before_rst", 32'(press_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outputs", 32'({press_valid, press_lane, start_pulse, lane_level, multi_press, overrun}), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(7);
    chk("t6_pv_after_rst", 32'(press_valid), 32'd1);
    chk("t6_pl_after_rst", 32'(press_lane), 32'b0010);
    tick(3);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
